multi_edge_detector: RTL and testbench

- Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel provides:
  - an input synchroniser;
  - a glitch filter that requires the level to be stable before it is accepted;
  - registered rise and fall pulses;
  - an event pulse qualified by a per-channel mode;
  - a sticky event flag with clear.
- Sits between asynchronous or noisy status inputs (buttons, external IRQ lines) and the interrupt/status logic.

---
 rtl/multi_edge_detector.sv | 183 ++++++++++++++++++
 tb/tb_multi_edge_detector.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
//
// Multi-channel conditioner for asynchronous or noisy status inputs (buttons,
// external IRQ lines). Each channel has its own synchroniser and glitch
// filter. It produces registered rise/fall pulses, a mode-qualified event
// pulse and a sticky event flag.
//
// Parameters:
//   NUM_CH      number of independent channels (>= 1)
//   SYNC_STAGES synchroniser flops per channel (0 = input used directly)
//   FILT_CYCLES extra consecutive mismatched samples before the filtered
//               level changes (0 = no filtering)
//   CNT_W       event counter width (only with MULTI_EDGE_CNT_EN)
//
// Optional feature: define MULTI_EDGE_CNT_EN to build a saturating per-channel
// event counter. Without it, cnt_o is tied to 0 and cnt_clr_i is ignored.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   reset_n         synchronous reset, active-low
//   a_i             raw channel inputs, may be asynchronous
//   mode_i          per-channel mode in [2k+1:2k]: 00 off, 01 rise, 10 fall,
//                   11 both
//   clr_i           per-channel sticky clear, level-sensitive
//   cnt_clr_i       per-channel counter clear
//   level_o         filtered level
//   rising_edge_o   one-cycle pulse on a filtered 0->1 change
//   falling_edge_o  one-cycle pulse on a filtered 1->0 change
//   event_o         one-cycle pulse on a mode-qualified edge
//   sticky_o        latched event flag
//   cnt_o           per-channel event counts, channel k in
//                   [CNT_W*(k+1)-1:CNT_W*k]
// -----------------------------------------------------------------------------
module multi_edge_detector #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         a_i,
  input  logic [2*NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH-1:0]         clr_i,
  input  logic [NUM_CH-1:0]         cnt_clr_i,
  output logic [NUM_CH-1:0]         level_o,
  output logic [NUM_CH-1:0]         rising_edge_o,
  output logic [NUM_CH-1:0]         falling_edge_o,
  output logic [NUM_CH-1:0]         event_o,
  output logic [NUM_CH-1:0]         sticky_o,
  output logic [NUM_CH*CNT_W-1:0]   cnt_o
);

  localparam int FC_W = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_CYCLES);

  // Synchronised input seen by the filter.
  logic [NUM_CH-1:0] sync_s;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync_s = a_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_d, sync_q;

      always_comb begin
        sync_d[0] = a_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // NOTE: the synchroniser chain is reset along with everything else, so
      // a stale sample can never leak into the filter after reset release.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign sync_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Filter, edge, event and sticky state.
  logic [NUM_CH-1:0][FC_W-1:0] fc_d, fc_q;
  logic [NUM_CH-1:0]           level_d, level_q;
  logic [NUM_CH-1:0]           rise_d, rise_q;
  logic [NUM_CH-1:0]           fall_d, fall_q;
  logic [NUM_CH-1:0]           event_d, event_q;
  logic [NUM_CH-1:0]           sticky_d, sticky_q;

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    fc_d    = fc_q;
    level_d = level_q;
    event_d = '0;

    for (int k = 0; k < NUM_CH; k++) begin
      if (sync_s[k] == level_q[k]) begin
        // Agreement at any point rejects a partial mismatch run.
        fc_d[k] = '0;
      end else if (fc_q[k] == FC_MAX) begin
        level_d[k] = sync_s[k];
        fc_d[k]    = '0;
      end else begin
        fc_d[k] = fc_q[k] + FC_W'(1);
      end
    end

    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;

    for (int k = 0; k < NUM_CH; k++) begin
      event_d[k] = (rise_d[k] & mode_i[2*k]) | (fall_d[k] & mode_i[2*k+1]);
    end

    // A new event wins over a simultaneous clear, so no event is lost.
    sticky_d = event_d | (sticky_q & ~clr_i);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fc_q     <= '0;
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
      sticky_q <= '0;
    end else begin
      fc_q     <= fc_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_o        = level_q;
  assign rising_edge_o  = rise_q;
  assign falling_edge_o = fall_q;
  assign event_o        = event_q;
  assign sticky_o       = sticky_q;

`ifdef MULTI_EDGE_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cnt_clr_i[k]) begin
        // A clear together with an event counts that event.
        cnt_d[k] = event_d[k] ? CNT_W'(1) : '0;
      end else if (event_d[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = |cnt_clr_i;
  assign cnt_o          = '0;
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_detector
//
// Self-checking bench for multi_edge_detector. The main instance uses the
// default channel/sync/filter parameters with a 3-bit counter. It is compared
// every cycle against a behavioural model that tracks input history and
// mismatch run lengths. A second single-channel instance with no synchroniser
// and no filter covers the minimum-latency corner. Directed sequences add
// constant-expectation checks on latency, glitch rejection, mode masking,
// sticky clearing, reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_multi_edge_detector;

  localparam int NC = 4;
  localparam int SS = 2;
  localparam int FC = 3;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC-1:0]     a_i = '0;
  logic [2*NC-1:0]   mode_i = '1;
  logic [NC-1:0]     clr_i = '0;
  logic [NC-1:0]     cnt_clr_i = '0;
  logic [NC-1:0]     level_o, rising_edge_o, falling_edge_o, event_o, sticky_o;
  logic [NC*CW-1:0]  cnt_o;

  // Minimum-latency instance.
  logic       a_m = 1'b0;
  logic       level_m, rise_m, fall_m, event_m, sticky_m;
  logic [2:0] cnt_m;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .NUM_CH(NC), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
    .cnt_clr_i(cnt_clr_i), .level_o(level_o), .rising_edge_o(rising_edge_o),
    .falling_edge_o(falling_edge_o), .event_o(event_o), .sticky_o(sticky_o),
    .cnt_o(cnt_o)
  );

  multi_edge_detector #(
    .NUM_CH(1), .SYNC_STAGES(0), .FILT_CYCLES(0), .CNT_W(3)
  ) dut_min (
    .clk(clk), .reset_n(reset_n), .a_i(a_m), .mode_i(2'b11), .clr_i(1'b0),
    .cnt_clr_i(1'b0), .level_o(level_m), .rising_edge_o(rise_m),
    .falling_edge_o(fall_m), .event_o(event_m), .sticky_o(sticky_m),
    .cnt_o(cnt_m)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NC-1:0]    hist [$];       // hist[i] = a_i sampled i+1 edges ago
  int               m_run [NC];     // consecutive edges where s != level
  int               m_cnt [NC];
  logic [NC-1:0]    m_level, m_rise, m_fall, m_event, m_sticky;
  logic [NC*CW-1:0] m_cnt_flat;

  task automatic model_step();
    logic [NC-1:0] s;
    logic [NC-1:0] new_level;
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back('0);
      m_level = '0; m_rise = '0; m_fall = '0; m_event = '0; m_sticky = '0;
      for (int k = 0; k < NC; k++) begin
        m_run[k] = 0;
        m_cnt[k] = 0;
      end
    end else begin
      s = hist[SS-1];
      hist.push_front(a_i);
      void'(hist.pop_back());
      new_level = m_level;
      for (int k = 0; k < NC; k++) begin
        if (s[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == FC + 1) begin
            new_level[k] = s[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        m_rise[k]   = new_level[k] && !m_level[k];
        m_fall[k]   = !new_level[k] && m_level[k];
        m_event[k]  = (m_rise[k] && mode_i[2*k]) || (m_fall[k] && mode_i[2*k+1]);
        m_sticky[k] = m_event[k] || (m_sticky[k] && !clr_i[k]);
`ifdef MULTI_EDGE_CNT_EN
        if (cnt_clr_i[k]) m_cnt[k] = m_event[k] ? 1 : 0;
        else if (m_event[k] && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
`endif
      end
      m_level = new_level;
    end
    for (int k = 0; k < NC; k++) m_cnt_flat[k*CW +: CW] = CW'(m_cnt[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("level", level_o, m_level);
    check("rise", rising_edge_o, m_rise);
    check("fall", falling_edge_o, m_fall);
    check("event", event_o, m_event);
    check("sticky", sticky_o, m_sticky);
    check("cnt", cnt_o, m_cnt_flat);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nr, nf, lv, ev2, ev3, hit;
    int rises [NC];

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    ticks(2);
    check("reset_outs", {level_o, rising_edge_o, falling_edge_o, event_o, sticky_o}, '0);
    check("reset_cnt", cnt_o, '0);
    reset_n = 1'b1;
    ticks(10);

    // ---------------- minimum-latency corner ----------------
    a_m = 1'b1;
    tick();
    check("min_rise", {level_m, rise_m, fall_m, event_m}, 4'b1101);
    tick();
    check("min_rise_end", {level_m, rise_m}, 2'b10);
    a_m = 1'b0;
    tick();
    check("min_fall", {level_m, rise_m, fall_m, event_m}, 4'b0011);
    tick();
    check("min_fall_end", fall_m, 1'b0);

    // ---------------- latency and edges, mode 11 ----------------
    mode_i = '1;
    a_i[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_rise", rising_edge_o[0], (i == 6));
      check("lat_event_r", event_o[0], (i == 6));
    end
    tick();
    check("lat_level_hi", {level_o[0], rising_edge_o[0]}, 2'b10);
    ticks(13);
    a_i[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("lat_fall", falling_edge_o[0], (i == 6));
      check("lat_event_f", event_o[0], (i == 6));
    end
    check("lat_level_lo", level_o[0], 1'b0);

    // ---------------- glitch rejection on ch1 ----------------
    nr = 0; lv = 0;
    a_i[1] = 1'b1;
    ticks(3);
    a_i[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nr += int'(rising_edge_o[1]);
      lv += int'(level_o[1]);
    end
    check("glitch_no_rise", nr, 0);
    check("glitch_no_level", lv, 0);
    nr = 0; nf = 0;
    a_i[1] = 1'b1;
    ticks(4);
    a_i[1] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      nr += int'(rising_edge_o[1]);
      nf += int'(falling_edge_o[1]);
    end
    check("pulse4_rise", nr, 1);
    check("pulse4_fall", nf, 1);

    // ---------------- mode masking and sticky on ch2/ch3 ----------------
    mode_i[5:4] = 2'b01;
    mode_i[7:6] = 2'b10;
    clr_i = '1;
    tick();
    clr_i = '0;
    ev2 = 0; ev3 = 0;
    a_i[3:2] = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      ev2 += int'(event_o[2]);
      ev3 += int'(event_o[3]);
      if (event_o[2]) check("ev2_on_rise", rising_edge_o[2], 1'b1);
    end
    check("ev2_rise_count", ev2, 1);
    check("ev3_masked_rise", ev3, 0);
    check("sticky_set", sticky_o[3:2], 2'b01);
    clr_i[3] = 1'b1;
    a_i[3:2] = 2'b00;
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      tick();
      if (event_o[3]) begin
        hit = 1;
        check("ev2_masked_fall", event_o[2], 1'b0);
        check("sticky_set_wins", sticky_o[3], 1'b1);
      end
    end
    check("ev3_timeout", hit, 1);
    tick();
    check("sticky_held_clr", sticky_o[3], 1'b0);
    clr_i[3] = 1'b0;
    clr_i[2] = 1'b1;
    tick();
    check("sticky_clr", sticky_o[2], 1'b0);
    clr_i[2] = 1'b0;
    ticks(4);

    // ---------------- reset behaviour ----------------
    mode_i = '1;
    a_i = '1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {level_o, rising_edge_o, falling_edge_o, event_o, sticky_o}, '0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < NC; k++) rises[k] = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int k = 0; k < NC; k++) rises[k] += int'(rising_edge_o[k]);
    end
    for (int k = 0; k < NC; k++) check("rst_one_rise", rises[k], 1);
    a_i = '0;
    ticks(12);
    a_i[0] = 1'b1;
    ticks(4);
    a_i[0] = 1'b0;
    reset_n = 1'b0;
    tick();
    check("midfilt_level", {level_o[0], rising_edge_o[0]}, 2'b00);
    reset_n = 1'b1;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nr += int'(rising_edge_o[0]);
    end
    check("midfilt_no_rise", nr, 0);

    // ---------------- counter ----------------
`ifdef MULTI_EDGE_CNT_EN
    cnt_clr_i = '1;
    tick();
    cnt_clr_i = '0;
    for (int n = 0; n < 9; n++) begin
      a_i[0] = ~a_i[0];
      ticks(8);
    end
    check("cnt_sat", cnt_o[CW-1:0], 3'd7);
    a_i[0] = ~a_i[0];
    cnt_clr_i[0] = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      tick();
      if (event_o[0]) begin
        hit = 1;
        check("cnt_clr_event", cnt_o[CW-1:0], 3'd1);
      end
    end
    check("cnt_ev_timeout", hit, 1);
    cnt_clr_i = '0;
`else
    for (int n = 0; n < 3; n++) begin
      a_i[0] = ~a_i[0];
      ticks(8);
    end
    check("cnt_tied_zero", cnt_o, '0);
`endif

    // ---------------- randomized phase ----------------
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NC; k++) begin
        if ($urandom_range(5) == 0) a_i[k] = ~a_i[k];
        clr_i[k]     = ($urandom_range(7) == 0);
        cnt_clr_i[k] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(49) == 0) mode_i = (2*NC)'($urandom);
      reset_n = ($urandom_range(199) != 0);
      tick();
    end
    reset_n = 1'b1;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
